// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encodings, the default
// data-memory timeout, widths and the EX/MEM pipeline register payload.
package memory_stage_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned DMEM_TIMEOUT = 16;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    // EX/MEM stage register contents
    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  wreg;
    } ex_mem_t;

    // Word accesses only: the two low address bits must be zero
    function automatic logic word_aligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: owns the IDLE/BUSY state, the wait-state
// counter, the sticky bus error and the pipeline stall.
// Ports:
//   start_i          launch an access on this edge (aligned load/store captured)
//   we_i/addr_i/wdata_i  captured access attributes from the stage register
//   dmem_ack_i       memory handshake completion
//   dmem_*_o         memory bus, derived only from registered state
//   mem_stall_c      hold upstream while an access is outstanding
//   ack_c            access completes on this edge
//   timeout_c        access is abandoned on this edge
//   bus_err_o        sticky timeout flag, cleared only by reset
module mem_access_fsm
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic              mem_stall_c,
    output logic              ack_c,
    output logic              timeout_c,
    output logic              bus_err_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             busy;

    assign busy = (state_q == MEM_BUSY);

    // Bus is quiet outside BUSY so a reset or idle cycle never shows stale attributes
    assign dmem_req_o   = busy;
    assign dmem_we_o    = busy & we_i;
    assign dmem_addr_o  = busy ? ADDR_W'(addr_i) : '0;
    assign dmem_wdata_o = busy ? wdata_i : '0;
    assign mem_stall_c  = busy & ~dmem_ack_i;
    assign ack_c        = busy & dmem_ack_i;
    assign bus_err_o    = bus_err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MEM_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state; an ack edge can chain straight into the next access
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        timeout_c = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (start_i) begin
                    state_d = MEM_BUSY;
                    cnt_d   = '0;
                end
            end
            MEM_BUSY: begin
                if (dmem_ack_i) begin
                    state_d = start_i ? MEM_BUSY : MEM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = MEM_IDLE;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    timeout_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, data-memory access through
// mem_access_fsm, writeback outputs and hazard-unit feedback.
// Ports:
//   RegWriteE/MemtoRegE/MemWriteE/ALUOutput/WriteDataE/WriteRegE  execute inputs
//   FlushM         capture a bubble instead of the execute instruction
//   dmem_*         req/ack data-memory bus
//   mem_stall      hold all upstream stages
//   *M             registered writeback outputs
//   ForwardMemVal/Hazard_*  forwarding value and destination for the hazard unit
//   align_err      one-cycle pulse after capturing a misaligned access
//   bus_err        sticky access timeout
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic [31:0]       ALUOutput,
    input  logic [31:0]       WriteDataE,
    input  logic [4:0]        WriteRegE,
    input  logic              FlushM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic [31:0]       ALUOutM,
    output logic [31:0]       ReadDataM,
    output logic [4:0]        WriteRegM,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic [31:0]       ForwardMemVal,
    output logic [4:0]        Hazard_WriteRegM,
    output logic              Hazard_RegWriteM,
    output logic              align_err,
    output logic              bus_err
);

    ex_mem_t           stage_q, stage_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              align_err_q, align_err_d;

    logic mem_op_c, aligned_c, capture_c, start_c, ack_c, timeout_c;

    assign mem_op_c  = MemtoRegE | MemWriteE;
    assign aligned_c = word_aligned(ALUOutput);
    assign capture_c = ~mem_stall;
    assign start_c   = capture_c & ~FlushM & mem_op_c & aligned_c;

    mem_access_fsm #(
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (ADDR_W)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_c),
        .we_i         (stage_q.memwrite),
        .addr_i       (stage_q.alu),
        .wdata_i      (stage_q.wdata),
        .dmem_ack_i   (dmem_ack),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .mem_stall_c  (mem_stall),
        .ack_c        (ack_c),
        .timeout_c    (timeout_c),
        .bus_err_o    (bus_err)
    );

    // Stage register next value; misaligned accesses lose their side effects
    always_comb begin
        stage_d     = stage_q;
        rdata_d     = rdata_q;
        align_err_d = 1'b0;
        if (capture_c) begin
            if (FlushM) begin
                stage_d = '0;
            end else begin
                stage_d.regwrite = RegWriteE & ~(mem_op_c & ~aligned_c);
                stage_d.memtoreg = MemtoRegE;
                stage_d.memwrite = MemWriteE & aligned_c;
                stage_d.alu      = ALUOutput;
                stage_d.wdata    = WriteDataE;
                stage_d.wreg     = WriteRegE;
                align_err_d      = mem_op_c & ~aligned_c;
            end
        end else if (timeout_c) begin
            stage_d.regwrite = 1'b0;
        end
        // Load data lands on the ack edge, even as the next instruction is captured
        if (ack_c && stage_q.memtoreg) begin
            rdata_d = dmem_rdata;
        end else if (timeout_c) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q     <= '0;
            rdata_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            rdata_q     <= rdata_d;
            align_err_q <= align_err_d;
        end
    end

    assign ALUOutM          = stage_q.alu;
    assign ReadDataM        = rdata_q;
    assign WriteRegM        = stage_q.wreg;
    assign RegWriteM        = stage_q.regwrite;
    assign MemtoRegM        = stage_q.memtoreg;
    assign ForwardMemVal    = stage_q.alu;
    assign Hazard_WriteRegM = stage_q.wreg;
    assign Hazard_RegWriteM = stage_q.regwrite;
    assign align_err        = align_err_q;

endmodule
